display_timings_480p: RTL
=========================

# display_timings_480p

Generates 640x480 @ 60 Hz raster timing in the pixel clock domain: screen coordinates, sync pulses, data-enable and frame/line strobes. Sits directly downstream of the pixel clock generator. It consumes `clk_pix` and the synchronised `clk_pix_locked`, and holds the raster idle until the PLL has been locked for a settle period. Its outputs feed the drawing logic and the video output (DVI/VGA) stage.

## Interface
- `CORDW`, 10: width of the coordinate outputs.
- `H_RES`, 640 / `H_FP`, 16 / `H_SYNC`, 96 / `H_BP`, 48: horizontal active width, front porch, sync and back porch, in pixels.
- `V_RES`, 480 / `V_FP`, 10 / `V_SYNC`, 2 / `V_BP`, 33: vertical active height, front porch, sync and back porch, in lines.
- `H_POL`, 0 / `V_POL`, 0: sync polarity. 0 means the pulse is driven low.
- `SETTLE`, 16: number of consecutive locked cycles required before the raster starts (minimum 1).
- `FCW`, 16: width of the frame counter.
- `clk_pix  in  1`: pixel clock.
- `rst  in  1`: reset. One clock; reset is asynchronous and active-high.
- `clk_pix_locked  in  1`: PLL lock, already synchronised to `clk_pix`.
- `running  out  1`: raster is active (state RUN).
- `sx  out  CORDW`: horizontal position, 0..H_TOTAL-1.
- `sy  out  CORDW`: vertical position, 0..V_TOTAL-1.
- `hsync  out  1`, `vsync  out  1`: sync outputs, polarity per `H_POL` / `V_POL`.
- `de  out  1`: data enable, high inside the active area.
- `line  out  1`: one-cycle strobe at the start of every line.
- `frame  out  1`: one-cycle strobe at the start of vertical blanking.
- `frame_cnt  out  FCW`: count of completed frames.

## Operation
- Derived constants: H_TOTAL = H_RES+H_FP+H_SYNC+H_BP = 800 and V_TOTAL = 525 at defaults.
- The state machine has three states:
  - IDLE → SETTLE when `clk_pix_locked`=1.
  - SETTLE counts locked cycles. It goes to RUN after `SETTLE` consecutive locked cycles. If lock drops during SETTLE, it returns to IDLE and the count clears.
  - RUN: when `clk_pix_locked`=0, it goes to IDLE on the next edge.
- In IDLE and SETTLE all outputs hold their reset values; `frame_cnt` keeps its value.
- In RUN:
  - `sx` increments every cycle and wraps H_TOTAL-1 → 0.
  - On wrap, `sy` increments and wraps V_TOTAL-1 → 0.
  - The first RUN cycle presents sx=0, sy=0.
- `de` = (sx < H_RES) && (sy < V_RES).
- hsync is asserted while sx is in [H_RES+H_FP, H_RES+H_FP+H_SYNC), which is 656..751 at defaults.
- vsync is asserted while sy is in [V_RES+V_FP, V_RES+V_FP+V_SYNC), which is 490..491 at defaults.
- Asserted level = `H_POL` / `V_POL`; the inactive level is its complement.
- `line` = 1 when sx==0 in RUN.
- `frame` = 1 when sx==0 and sy==V_RES (480).
- `frame_cnt` increments by 1 in the same cycle `frame` is high, and wraps at 2^FCW.
- All parameters must give totals below 2^CORDW; this is checked by elaboration assertion.

## Timing
- Every output is a flop output; there are no combinational paths from inputs.
- `hsync`, `vsync`, `de`, `line` and `frame` are cycle-aligned with the `sx`/`sy` values they describe (computed from next-state counters).
- Reset values: running=0, sx=0, sy=0, de=0, line=0, frame=0, frame_cnt=0, hsync=~H_POL, vsync=~V_POL, state=IDLE.
- Startup latency: lock rising at edge N gives running=1 and sx=0, sy=0 at edge N+SETTLE+1.
- Lock drop mid-frame: at the next edge the outputs return to reset values, except frame_cnt, which holds. A later restart begins at (0,0).
- `rst` asserted mid-frame clears everything immediately, including frame_cnt.
- Line period is H_TOTAL cycles; frame period is H_TOTAL*V_TOTAL = 420000 cycles.

## Structure
- Package `display_pkg` holds:
  - the state enum (IDLE, SETTLE, RUN);
  - default 640x480 timing localparams;
  - a function computing H_TOTAL / V_TOTAL.
- Sub-module `lock_settle` holds the IDLE/SETTLE/RUN FSM and settle counter; its output is `running`. The top holds the raster counters and decode.

## Test plan
- Reset release, lock held high from cycle 5, SETTLE=16 → running=1 with sx=0, sy=0 at cycle 22; all outputs at reset values before that.
- One full frame → de high for exactly 307200 cycles; hsync low for 96 cycles per line starting at sx=656; vsync low for exactly lines 490–491 (1600 cycles); line strobes 525 times.
- Frame boundaries → frame pulses once per 420000 cycles at (0,480); frame_cnt goes 0→1→2; force frame_cnt to 0xFFFF and check it wraps to 0.
- Lock glitch low for 1 cycle during SETTLE at count 10 → returns to IDLE, and start is delayed by a full new 16-cycle settle.
- Lock drop at (300,200) in RUN → next cycle running=0, sx=sy=0, sync lines inactive, frame_cnt held; relock restarts at (0,0) after settle.
- Async `rst` pulse mid-line, not aligned to a clock edge → outputs reset without waiting for an edge, frame_cnt=0; the sequence restarts from IDLE.

Source files
------------

// File: rtl/display_pkg.sv
// display_pkg: shared definitions for the 640x480 raster timing block.
//   state_t       - lock/settle/run state encoding
//   DEF_*         - default 640x480 @ 60 Hz timing values
//   timing_total  - sum of active, front porch, sync and back porch
package display_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_RUN
  } state_t;

  localparam int DEF_H_RES  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;

  localparam int DEF_V_RES  = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;

  function automatic int timing_total(input int res, input int fp,
                                      input int sync, input int bp);
    return res + fp + sync + bp;
  endfunction

endpackage

// File: rtl/display_timings_480p_lock_settle.sv
// lock_settle: waits for the pixel PLL to stay locked for SETTLE_CYCLES
// consecutive cycles before allowing the raster to run.
//   clk      in  - pixel clock
//   rst      in  - asynchronous active-high reset
//   locked   in  - PLL lock, already synchronised to clk
//   running  out - registered, high while in S_RUN
//   run_next out - combinational next value of running; lets the raster
//                  registers change on the same edge as the state
module lock_settle
  import display_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic locked,
  output logic running,
  output logic run_next
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      running <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      running <= run_next;
    end
  end

  // cnt holds the number of locked cycles seen while in S_SETTLE; the
  // transition to S_RUN happens on the cycle after it reaches the target.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE: begin
        cnt_next = '0;
        if (locked) state_next = S_SETTLE;
      end
      S_SETTLE: begin
        if (!locked) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end else if (cnt == CW'(SETTLE_CYCLES)) begin
          state_next = S_RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      S_RUN: begin
        cnt_next = '0;
        if (!locked) state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign run_next = (state_next == S_RUN);

endmodule

// File: rtl/display_timings_480p.sv
// display_timings_480p: 640x480 @ 60 Hz raster timing in the pixel clock domain.
//   clk_pix         in  - pixel clock
//   rst             in  - asynchronous active-high reset
//   clk_pix_locked  in  - PLL lock, synchronised to clk_pix
//   running         out - raster active
//   sx, sy          out - screen position (CORDW bits)
//   hsync, vsync    out - sync pulses, asserted level H_POL / V_POL
//   de              out - data enable inside the active area
//   line            out - strobe at sx == 0
//   frame           out - strobe at start of vertical blanking (0, V_RES)
//   frame_cnt       out - completed frame count (FCW bits, wraps)
// All outputs are registered; decodes use the next counter values so each
// strobe lines up with the position it describes.
module display_timings_480p
  import display_pkg::*;
#(
  parameter int   CORDW  = 10,
  parameter int   H_RES  = DEF_H_RES,
  parameter int   H_FP   = DEF_H_FP,
  parameter int   H_SYNC = DEF_H_SYNC,
  parameter int   H_BP   = DEF_H_BP,
  parameter int   V_RES  = DEF_V_RES,
  parameter int   V_FP   = DEF_V_FP,
  parameter int   V_SYNC = DEF_V_SYNC,
  parameter int   V_BP   = DEF_V_BP,
  parameter logic H_POL  = 1'b0,
  parameter logic V_POL  = 1'b0,
  parameter int   SETTLE = 16,
  parameter int   FCW    = 16
) (
  input  logic             clk_pix,
  input  logic             rst,
  input  logic             clk_pix_locked,
  output logic             running,
  output logic [CORDW-1:0] sx,
  output logic [CORDW-1:0] sy,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             line,
  output logic             frame,
  output logic [FCW-1:0]   frame_cnt
);

  localparam int H_TOTAL = timing_total(H_RES, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = timing_total(V_RES, V_FP, V_SYNC, V_BP);
  localparam int HS_BEG  = H_RES + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_RES + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;

  if (H_TOTAL >= (1 << CORDW) || V_TOTAL >= (1 << CORDW)) begin : g_bad_totals
    $error("display_timings_480p: totals do not fit in CORDW bits");
  end
  if (SETTLE < 1) begin : g_bad_settle
    $error("display_timings_480p: SETTLE must be at least 1");
  end

  logic run_next;

  lock_settle #(
    .SETTLE_CYCLES(SETTLE)
  ) u_lock_settle (
    .clk     (clk_pix),
    .rst     (rst),
    .locked  (clk_pix_locked),
    .running (running),
    .run_next(run_next)
  );

  logic [CORDW-1:0] sx_n;
  logic [CORDW-1:0] sy_n;
  logic             de_n;
  logic             hsync_n;
  logic             vsync_n;
  logic             line_n;
  logic             frame_n;

  always_comb begin
    sx_n = sx;
    sy_n = sy;
    if (!run_next || !running) begin
      // outside RUN, and on the first RUN cycle, the raster sits at (0,0)
      sx_n = '0;
      sy_n = '0;
    end else if (sx == CORDW'(H_TOTAL - 1)) begin
      sx_n = '0;
      sy_n = (sy == CORDW'(V_TOTAL - 1)) ? '0 : sy + CORDW'(1);
    end else begin
      sx_n = sx + CORDW'(1);
    end

    de_n    = run_next && (sx_n < CORDW'(H_RES)) && (sy_n < CORDW'(V_RES));
    hsync_n = (run_next && sx_n >= CORDW'(HS_BEG) && sx_n < CORDW'(HS_END))
              ? H_POL : ~H_POL;
    vsync_n = (run_next && sy_n >= CORDW'(VS_BEG) && sy_n < CORDW'(VS_END))
              ? V_POL : ~V_POL;
    line_n  = run_next && (sx_n == '0);
    frame_n = run_next && (sx_n == '0) && (sy_n == CORDW'(V_RES));
  end

  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      sx        <= '0;
      sy        <= '0;
      de        <= 1'b0;
      hsync     <= ~H_POL;
      vsync     <= ~V_POL;
      line      <= 1'b0;
      frame     <= 1'b0;
      frame_cnt <= '0;
    end else begin
      sx    <= sx_n;
      sy    <= sy_n;
      de    <= de_n;
      hsync <= hsync_n;
      vsync <= vsync_n;
      line  <= line_n;
      frame <= frame_n;
      if (frame_n) frame_cnt <= frame_cnt + FCW'(1);
    end
  end

endmodule
